// File: rtl/imm_dec_stage.sv
// Immediate-decode pipeline stage: decodes RV32I/RV64I immediates at push time
// and holds results in a 2-entry skid buffer with synchronous flush.
module imm_dec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned TW    = 3;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 2;
  localparam bit          IS64  = (XLEN == 64);

  localparam logic [TW-1:0] T_NONE = 3'd0;
  localparam logic [TW-1:0] T_I    = 3'd1;
  localparam logic [TW-1:0] T_S    = 3'd2;
  localparam logic [TW-1:0] T_B    = 3'd3;
  localparam logic [TW-1:0] T_U    = 3'd4;
  localparam logic [TW-1:0] T_J    = 3'd5;
  localparam logic [TW-1:0] T_Z    = 3'd6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt5, shamt6, zimm;
  logic [XLEN-1:0] dec_imm;
  logic [TW-1:0]   dec_type;
  logic            dec_ill;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];

  assign imm_i  = XLEN'($signed(i_instr[31:20]));
  assign imm_s  = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign imm_b  = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
  assign shamt5 = XLEN'(i_instr[24:20]);
  assign shamt6 = XLEN'(i_instr[25:20]);
  assign zimm   = XLEN'(i_instr[19:15]);

  // Opcodes not matched here (including any with instr[1:0] != 11) are illegal.
  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_type = T_I;
        dec_imm  = imm_i;
      end
      7'b0010011: begin
        dec_type = T_I;
        if (funct3[1:0] == 2'b01) dec_imm = IS64 ? shamt6 : shamt5;
        else                      dec_imm = imm_i;
      end
      7'b0011011: begin
        if (IS64) begin
          dec_type = T_I;
          dec_imm  = (funct3[1:0] == 2'b01) ? shamt5 : imm_i;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_type = T_S;
        dec_imm  = imm_s;
      end
      7'b1100011: begin
        dec_type = T_B;
        dec_imm  = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        dec_type = T_U;
        dec_imm  = imm_u;
      end
      7'b1101111: begin
        dec_type = T_J;
        dec_imm  = imm_j;
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_type = T_Z;
          dec_imm  = zimm;
        end
      end
      7'b0110011: dec_ill = 1'b0;
      7'b0111011: dec_ill = !IS64;
      default:    dec_ill = 1'b1;
    endcase
  end

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] imm_q   [DEPTH];
  logic [TW-1:0]   type_q  [DEPTH];
  logic            ill_q   [DEPTH];
  logic            head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;

  assign o_ready = (count_q < CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // Buffer state; reset beats flush, flush beats push/pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= '0;
        type_q[i]  <= T_NONE;
        ill_q[i]   <= 1'b0;
      end
    end else if (i_flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        instr_q[tail_q] <= i_instr;
        pc_q[tail_q]    <= i_pc;
        imm_q[tail_q]   <= dec_imm;
        type_q[tail_q]  <= dec_type;
        ill_q[tail_q]   <= dec_ill;
        tail_q          <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_instr    = instr_q[head_q];
  assign o_pc       = pc_q[head_q];
  assign o_imm      = imm_q[head_q];
  assign o_imm_type = type_q[head_q];
  assign o_illegal  = ill_q[head_q];

endmodule

// File: doc/imm_dec_stage.md
# imm_dec_stage

Registered, XLEN-parametrised immediate-decode pipeline stage for the RISC-V core. It sits between fetch and execute. It accepts instruction/PC pairs on a valid/ready handshake and decodes the immediate for every RV32I/RV64I format, plus CSR zimm and RV64 shift amounts. Results are held in a 2-entry skid buffer with synchronous flush, so execute stalls never drop or duplicate an instruction.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; equals (count < 2).
- i_instr  in  32  instruction word.
- i_pc  in  XLEN  instruction PC.
- i_flush  in  1  synchronous kill of all buffered entries.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head entry.
- o_instr  out  32  head instruction.
- o_pc  out  XLEN  head PC.
- o_imm  out  XLEN  decoded immediate.
- o_imm_type  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm).
- o_illegal  out  1  unknown opcode, or instr[1:0] != 2'b11.

## Operation
- Decode is combinational on i_instr and is written into the buffer at push.
- Opcode 0000011 (LOAD), 1100111 (JALR): type I, {sext instr[31:20]}.
- Opcode 0010011 (OP-IMM), and 0011011 (OP-IMM-32) when XLEN=64:
  - funct3 001/101: type I, imm = zero-extended shamt.
  - Shamt field: instr[24:20] for XLEN=32 or OP-IMM-32; instr[25:20] for XLEN=64 OP-IMM.
  - Other funct3: type I, sign-extended.
- 0100011 (STORE): type S, sext {instr[31:25], instr[11:7]}.
- 1100011 (BRANCH): type B, sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 0110111 (LUI), 0010111 (AUIPC): type U, sext {instr[31:12], 12'b0}; bit 31 replicates into the upper half when XLEN=64.
- 1101111 (JAL): type J, sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- 1110011 (SYSTEM):
  - funct3[2]=1: type Z, imm = zero-extended instr[19:15].
  - Otherwise: type NONE, imm 0.
- 0110011 (OP), and 0111011 when XLEN=64: type NONE, imm 0, legal.
- Any other opcode, 0011011/0111011 when XLEN=32, or instr[1:0] != 11: type NONE, imm 0, o_illegal=1. The entry is still buffered and passed downstream.
- Buffer: 2-entry FIFO with head pointer, tail pointer and 2-bit count.
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - Output fields are driven from the head entry.
- Push and pop in the same cycle with count=1: the head is replaced by the new entry; count stays 1.
- Push when count=2 is impossible because o_ready=0; any i_valid is ignored.
- Pop when count=0 is impossible because o_valid=0.
- Flush: count goes to 0 and pointers to 0. A push in the same cycle is discarded.
- Reset has priority over flush; flush has priority over push and pop.

## Timing
- Reset values:
  - o_valid=0, o_ready=1, count=0.
  - o_imm=0, o_imm_type=0, o_illegal=0, o_instr=0, o_pc=0.
  - Entries are cleared.
- Latency: an entry pushed at edge N is visible with o_valid=1 after edge N, so it can be consumed in cycle N+1.
- Throughput: 1 instruction per cycle while i_ready=1.
- o_ready is registered-derived from count, with no combinational path from i_ready. This is what makes the block a skid buffer.
- With i_ready low: accepts at most 2 entries, then o_ready=0 until a pop.
- While o_valid=0, the output data fields show the last popped or reset contents.
  - Downstream must qualify them with o_valid.
  - The bench checks them only when o_valid=1.
- Reset asserted mid-stream: all buffered entries are lost at the next edge, and o_valid=0 from that edge.

## Test plan
- XLEN=32. Stream, in order:
  - lui x5,4 = 0x000042B7 -> imm 0x00004000, type U.
  - addi x26,x17,-5 = 0xFFB88D13 -> imm 0xFFFFFFFB, type I.
  - beq x20,x19,12 = 0x013A0663 -> imm 12, type B.
  - With i_ready=1, each output appears one cycle after its push, in order.
- XLEN=32:
  - srai x11,x10,12 = 0x40C55593 -> imm 12, not 0x40C.
  - csrrwi x1,0x300,5 = 0x3002D0F3 -> imm 5, type Z.
  - 0x0000007F -> o_illegal=1, type NONE, imm 0.
- XLEN=64:
  - lui 0x800002B7 -> imm 0xFFFFFFFF80000000.
  - slli with instr[25:20]=33 -> imm 33.
  - 0x0000001B (OP-IMM-32) legal.
- Backpressure:
  - Hold i_ready=0 and push 3 instructions -> o_ready=0 after the 2nd; the 3rd is not accepted.
  - Release i_ready -> entries pop in order and o_ready returns to 1.
- With count=2, assert i_flush together with i_valid -> next cycle o_valid=0, count=0, and the new instruction is dropped.
- Assert i_rst_n=0 for one cycle while streaming -> o_valid=0 and o_ready=1 after that edge, and all outputs are 0.
